tick_period_meter: RTL
======================

// Module: tick_period_meter
// PURPOSE
//  Receive-side partner of the ring counter: measures the period of a 1-cycle tick stream (e.g. a counter's done_o).
//  Reports the number of enabled cycles strictly between consecutive ticks, so a generator running with
//  i_num_cnt = N and en held high reads back as N.
//  Sits after any tick source; result is presented on a valid/ready output register.
// PARAMETERS
//  WIDTH  8  width of the internal period counter and of meas_o; saturates at 2^WIDTH-1
// PORTS
//  clk      in   1      clock; all state updates on posedge
//  rst      in   1      reset; asynchronous, active-high
//  en       in   1      enable; counting and tick acceptance happen only when en=1
//  clr      in   1      synchronous clear: return to IDLE, drop pending result (valid_o<=0)
//  tick_i   in   1      1-cycle tick to measure; sampled only when en=1
//  ready_i  in   1      consumer accepts result when valid_o & ready_i
//  meas_o   out  WIDTH  measured period (enabled cycles between ticks)
//  ovf_o    out  1      meas_o saturated (true period > 2^WIDTH-1); qualified by valid_o
//  valid_o  out  1      result held in output register
//  lost_o   out  1      1-cycle pulse: unconsumed result overwritten by a newer one
//  busy_o   out  1      1 in MEAS state (armed, counting)
// BEHAVIOUR
//  Reset (async, any time incl. mid-measurement): state=IDLE, cnt=0, sat=0, meas_o=0, ovf_o=0, valid_o=0,
//   lost_o=0, busy_o=0. First tick after reset only arms; it never produces a result.
//  FSM: IDLE --(en&tick_i)--> MEAS (cnt<=0, sat<=0). MEAS stays in MEAS; clr from any state -> IDLE.
//   clr has priority over tick_i and en; clr also clears valid_o, sat and cnt.
//  MEAS, en=1, tick_i=0: if cnt==2^WIDTH-1 then sat<=1 (cnt holds) else cnt<=cnt+1.
//  MEAS, en=1, tick_i=1: result {meas=cnt, ovf=sat} loaded to output register; cnt<=0, sat<=0 (next period
//   starts with this tick, back-to-back ticks give meas=0).
//  en=0: cnt, sat, state frozen; tick_i ignored (no arm, no result).
//  Latency: valid_o/meas_o update on the posedge that samples the closing tick (visible next cycle).
//  Exact max: period of 2^WIDTH-1 enabled cycles reports meas=2^WIDTH-1, ovf=0; one more -> same meas, ovf=1.
//  Output handshake: valid_o&ready_i consumes -> valid_o<=0 unless a new result loads the same cycle.
//   New result while valid_o=1 & ready_i=0: overwrite meas_o/ovf_o, valid_o stays 1, lost_o=1 for one cycle.
//   New result while valid_o=1 & ready_i=1: old consumed, new loaded, valid_o stays 1, lost_o=0.
//   meas_o/ovf_o stable while valid_o=1 & no new result; they hold last value after consumption.
//  lost_o is registered, 0 in all other cycles; busy_o = (state==MEAS).
// CONFIGURATION
//  Macro TICK_PERIOD_METER_MATCH_EN:
//   defined: adds ports exp_i (in, WIDTH, expected period) and match_o (out, 1). match_o is registered with
//    the result: match_o = (cnt==exp_i) & ~sat at load time; held with meas_o; reset 0; cleared by clr.
//   undefined: exp_i and match_o absent; no compare logic; all other behaviour identical.
// TESTING
//  1 en=1, ready_i=1, tick_i every 6 cycles (5 quiet cycles) -> first tick arms only; each later tick gives
//    valid_o=1 one cycle later with meas_o=5, ovf_o=0, lost_o=0.
//  2 en toggling 1/0 each cycle, ticks 10 cycles apart on en=1 cycles -> meas_o=4; tick on en=0 cycle ignored.
//  3 WIDTH=8, arm then ticks after 255 and after 300 enabled quiet cycles -> meas_o=255 ovf_o=0, then
//    meas_o=255 ovf_o=1.
//  4 ready_i=0, periods 3 then 7 -> valid_o=1 meas_o=3, then meas_o=7 with lost_o pulse; ready_i=1 -> valid_o=0.
//  5 rst pulsed mid-period with valid_o=1 -> all outputs 0 immediately; next tick arms only; clr mid-period
//    likewise returns busy_o=0, valid_o=0.
//  6 MATCH_EN, ring counter i_num_cnt=5 driving tick_i, exp_i=5 -> meas_o=5 match_o=1; exp_i=4 -> match_o=0.

Source files
------------

// File: rtl/tick_period_meter.sv
// Measures enabled cycles between consecutive 1-cycle ticks; result on a valid/ready register.
// Optional TICK_PERIOD_METER_MATCH_EN adds exp_i/match_o period comparison.
module tick_period_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             tick_i,
  input  logic             ready_i,
`ifdef TICK_PERIOD_METER_MATCH_EN
  input  logic [WIDTH-1:0] exp_i,
  output logic             match_o,
`endif
  output logic [WIDTH-1:0] meas_o,
  output logic             ovf_o,
  output logic             valid_o,
  output logic             lost_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic             r_sat;
  logic [WIDTH-1:0] r_meas;
  logic             r_ovf;
  logic             r_valid;
  logic             r_lost;
  logic             w_tick;
  logic             w_load;
  logic             w_busy;

  assign w_tick = en & tick_i & ~clr;
  assign w_load = w_tick & (r_state == MEAS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_tick) w_state_nxt = MEAS;
        MEAS: w_state_nxt = MEAS;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state == MEAS);
  end

  // Period counter; saturation is sticky until the closing tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (en && r_state == MEAS) begin
      if (r_cnt == MAX) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meas <= '0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_meas <= r_cnt;
      r_ovf  <= r_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_lost <= w_load & r_valid & ~ready_i;
      if (clr) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef TICK_PERIOD_METER_MATCH_EN
  logic r_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if (clr) begin
      r_match <= 1'b0;
    end else if (w_load) begin
      r_match <= (r_cnt == exp_i) & ~r_sat;
    end
  end

  assign match_o = r_match;
`endif

  assign meas_o  = r_meas;
  assign ovf_o   = r_ovf;
  assign valid_o = r_valid;
  assign lost_o  = r_lost;
  assign busy_o  = w_busy;

endmodule
